mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester of the 5-stage pipeline CPU.
- Each request is sequenced onto the memory's req/ack handshake. Read data and one-cycle completion pulses are returned to each requester.
- Drives stall_o to the pipeline (PC, IF_ID, hazard logic) while any request is outstanding.
- Bounds memory wait time with a sticky timeout error.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory-port logic.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_WAIT_MAX = 16;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arb_state_e;

    // Requester identity; the value doubles as the bit index in request vectors.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_id_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that did not win last time.
module arb_rr2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  grant_id_e  last_grant,
    output logic       valid,
    output grant_id_e  grant
);

    // Pick a winner from the request vector.
    always_comb begin
        valid = |req;
        grant = FETCH;
        if (req[DATA] && req[FETCH]) begin
            grant = (last_grant == FETCH) ? DATA : FETCH;
        end else if (req[DATA]) begin
            grant = DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters,
// stalls the pipeline while a request is outstanding and bounds memory wait
// time with a sticky timeout flag.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = 8;
    // Last un-acked grant cycle allowed before the access is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    grant_id_e         last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic [1:0]        elig;
    logic              pick_valid;
    grant_id_e         pick;
    logic              done;
    logic [DATA_W-1:0] done_data;

    // A requester that completes this cycle is masked so its held request
    // is not mistaken for a new one.
    assign elig = {d_req_i & ~d_ready_q, if_req_i & ~if_ready_q};

    arb_rr2 u_arb (
        .req        (elig),
        .last_grant (last_q),
        .valid      (pick_valid),
        .grant      (pick)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        done        = 1'b0;
        done_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    mem_req_d = 1'b1;
                    last_d    = pick;
                    cnt_d     = '0;
                    if (pick == DATA) begin
                        state_d     = GNT_D;
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                    end else begin
                        state_d     = GNT_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            GNT_D, GNT_I: begin
                if (mem_ack_i) begin
                    done      = 1'b1;
                    // Stores return zero rather than whatever the bus carries.
                    done_data = mem_we_q ? '0 : mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            cnt_d     = '0;
            if (state_q == GNT_D) begin
                d_ready_d = 1'b1;
                d_rdata_d = done_data;
            end else begin
                if_ready_d = 1'b1;
                if_rdata_d = done_data;
            end
        end
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= FETCH;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ready_o  = if_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ready_o   = d_ready_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;

    // Gated by reset so the pipeline sees no stall while the port is held in reset.
    assign stall_o = ~rst_i & ((if_req_i & ~if_ready_q) | (d_req_i & ~d_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int WMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ready_o, d_ready_o, mem_req_o, mem_we_o, stall_o, err_o;

    int checks = 0;
    int errors = 0;

    // Memory responder controls.
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rdata_val = '0;
    bit          force_idle_ack = 1'b0;

    // Grants observed on the DUT memory port.
    logic [31:0] g_addr[$];
    logic        g_we[$];
    logic [31:0] g_wdata[$];

    // Model state: owner -1 = none, 0 = fetch, 1 = data.
    int          m_owner = -1;
    int          m_wait = 0;
    int          m_last = 0;
    bit          m_if_ready = 1'b0, m_d_ready = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0, m_addr = '0, m_wdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata_o),
        .d_ready_o   (d_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a completion pulse; cycles counts negedges sampled.
    task automatic wait_ready(input bit is_data, input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if ((is_data ? d_ready_o : if_ready_o) === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_%s got=no_ready want=ready_within_%0d t=%0t",
                 is_data ? "d" : "if", budget, $time);
    endtask

    task automatic check_grant(input string name, input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata);
        if (g_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=no_grant want=addr_%08h t=%0t", name, addr, $time);
        end else begin
            check32({name, "_addr"}, g_addr.pop_front(), addr);
            check1({name, "_we"}, g_we.pop_front(), we);
            check32({name, "_wdata"}, g_wdata.pop_front(), wdata);
        end
    endtask

    task automatic clear_grants();
        g_addr.delete();
        g_we.delete();
        g_wdata.delete();
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req_o being high.
    initial begin
        int seen;
        seen = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                seen = 0;
                mem_ack = 1'b0;
            end else if (mem_req_o) begin
                if (ack_en && seen == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata_val;
                end else begin
                    mem_ack = 1'b0;
                end
                seen++;
            end else begin
                seen = 0;
                mem_ack = force_idle_ack;
                mem_rdata = force_idle_ack ? 32'hBAD0_BAD0 : '0;
            end
        end
    end

    // Transaction-level model: one owner at a time, round-robin on ties,
    // completion on ack or after WMAX silent grant cycles.
    initial begin
        bit          nif, nd, ef, ed, fin;
        int          pick;
        logic [31:0] data;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = -1;
                m_wait = 0;
                m_last = 0;
                m_if_ready = 1'b0;
                m_d_ready = 1'b0;
                m_if_rdata = '0;
                m_d_rdata = '0;
                m_err = 1'b0;
            end else begin
                nif = 1'b0;
                nd = 1'b0;
                if (m_owner < 0) begin
                    ef = if_req && !m_if_ready;
                    ed = d_req && !m_d_ready;
                    pick = -1;
                    if (ef && ed) pick = 1 - m_last;
                    else if (ed) pick = 1;
                    else if (ef) pick = 0;
                    if (pick >= 0) begin
                        m_owner = pick;
                        m_last = pick;
                        m_wait = 0;
                        m_addr = (pick == 1) ? d_addr : if_addr;
                        m_we = (pick == 1) ? d_we : 1'b0;
                        m_wdata = (pick == 1) ? d_wdata : '0;
                    end
                end else begin
                    fin = 1'b0;
                    data = '0;
                    if (mem_ack) begin
                        fin = 1'b1;
                        data = (m_owner == 1 && m_we) ? '0 : mem_rdata;
                    end else begin
                        m_wait++;
                        if (m_wait >= WMAX) begin
                            fin = 1'b1;
                            m_err = 1'b1;
                        end
                    end
                    if (fin) begin
                        if (m_owner == 1) begin
                            nd = 1'b1;
                            m_d_rdata = data;
                        end else begin
                            nif = 1'b1;
                            m_if_rdata = data;
                        end
                        m_owner = -1;
                    end
                end
                m_if_ready = nif;
                m_d_ready = nd;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check1("rst_mem_req", mem_req_o, 1'b0);
                check1("rst_if_ready", if_ready_o, 1'b0);
                check1("rst_d_ready", d_ready_o, 1'b0);
                check1("rst_err", err_o, 1'b0);
                check1("rst_stall", stall_o, 1'b0);
            end else begin
                check1("mem_req", mem_req_o, m_owner >= 0);
                if (m_owner >= 0) begin
                    check32("mem_addr", mem_addr_o, m_addr);
                    check1("mem_we", mem_we_o, m_we);
                    check32("mem_wdata", mem_wdata_o, m_wdata);
                end
                check1("if_ready", if_ready_o, m_if_ready);
                check1("d_ready", d_ready_o, m_d_ready);
                if (m_if_ready) check32("if_rdata", if_rdata_o, m_if_rdata);
                if (m_d_ready) check32("d_rdata", d_rdata_o, m_d_rdata);
                check1("err", err_o, m_err);
                check1("stall", stall_o, (if_req && !m_if_ready) || (d_req && !m_d_ready));
            end
        end
    end

    // Grant monitor: record the request presented on each rising mem_req_o.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_o && !prev) begin
                g_addr.push_back(mem_addr_o);
                g_we.push_back(mem_we_o);
                g_wdata.push_back(mem_wdata_o);
            end
            prev = !rst && mem_req_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int cyc;
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check1("reset_mem_req", mem_req_o, 1'b0);
        check1("reset_err", err_o, 1'b0);
        check1("reset_stall", stall_o, 1'b0);

        // Single fetch, ack two cycles after the request appears.
        clear_grants();
        rdata_val = 32'h2002_000A;
        ack_delay = 2;
        if_addr = 32'h40;
        if_req = 1'b1;
        #1;
        check1("fetch_stall_on", stall_o, 1'b1);
        wait_ready(1'b0, 20, cyc);
        check32("fetch_latency", cyc, 32'd5);
        check32("fetch_rdata", if_rdata_o, 32'h2002_000A);
        check1("fetch_stall_off", stall_o, 1'b0);
        check_grant("fetch", 32'h40, 1'b0, 32'h0);
        tick(1);
        if_req = 1'b0;
        tick(1);

        // Store with immediate ack; store returns zero data.
        clear_grants();
        rdata_val = 32'h1234_5678;
        ack_delay = 0;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        d_req = 1'b1;
        wait_ready(1'b1, 20, cyc);
        check32("store_latency", cyc, 32'd3);
        check32("store_rdata", d_rdata_o, 32'h0);
        check_grant("store", 32'h100, 1'b1, 32'hDEAD_BEEF);
        tick(1);
        d_req = 1'b0;
        d_we = 1'b0;
        tick(1);

        // Contention from reset: data wins first, then strict alternation.
        rst = 1'b1;
        clear_grants();
        if_addr = 32'h200;
        d_addr = 32'h300;
        d_wdata = 32'h0;
        if_req = 1'b1;
        d_req = 1'b1;
        ack_delay = 1;
        rdata_val = 32'h0000_CAFE;
        tick(2);
        rst = 1'b0;
        tick(14);
        check_grant("cont0", 32'h300, 1'b0, 32'h0);
        check_grant("cont1", 32'h200, 1'b0, 32'h0);
        check_grant("cont2", 32'h300, 1'b0, 32'h0);
        check_grant("cont3", 32'h200, 1'b0, 32'h0);

        // Data drops right after its ready; fetch granted after one idle cycle.
        wait_ready(1'b1, 10, cyc);
        check32("cont_d_rdata", d_rdata_o, 32'h0000_CAFE);
        clear_grants();
        tick(1);
        d_req = 1'b0;
        @(negedge clk);
        check1("drop_next_grant", mem_req_o, 1'b1);
        check32("drop_next_addr", mem_addr_o, 32'h200);
        wait_ready(1'b0, 10, cyc);
        tick(1);
        if_req = 1'b0;
        tick(2);

        // Timeout: a load with no ack aborts after WMAX grant cycles.
        ack_en = 1'b0;
        d_addr = 32'h180;
        d_req = 1'b1;
        wait_ready(1'b1, 20, cyc);
        check32("timeout_latency", cyc, 32'd6);
        check32("timeout_rdata", d_rdata_o, 32'h0);
        check1("timeout_err", err_o, 1'b1);
        tick(1);
        d_req = 1'b0;
        ack_en = 1'b1;
        ack_delay = 0;
        tick(1);
        rdata_val = 32'h0BAD_F00D;
        if_addr = 32'h44;
        if_req = 1'b1;
        wait_ready(1'b0, 20, cyc);
        check32("post_to_latency", cyc, 32'd3);
        check32("post_to_rdata", if_rdata_o, 32'h0BAD_F00D);
        check1("err_sticky", err_o, 1'b1);
        tick(1);
        if_req = 1'b0;
        tick(1);

        // Stray ack while idle must be ignored.
        force_idle_ack = 1'b1;
        tick(3);
        force_idle_ack = 1'b0;
        check1("idle_ack_no_req", mem_req_o, 1'b0);
        check1("idle_ack_no_ready", d_ready_o | if_ready_o, 1'b0);
        tick(1);

        // Asynchronous reset in the middle of a fetch grant.
        ack_en = 1'b0;
        if_addr = 32'h88;
        if_req = 1'b1;
        tick(2);
        check1("pre_rst_mem_req", mem_req_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_mem_req", mem_req_o, 1'b0);
        check1("async_rst_stall", stall_o, 1'b0);
        check1("async_rst_if_ready", if_ready_o, 1'b0);
        check1("async_rst_err", err_o, 1'b0);
        tick(2);
        ack_en = 1'b1;
        ack_delay = 0;
        rdata_val = 32'h0000_0088;
        clear_grants();
        rst = 1'b0;
        wait_ready(1'b0, 10, cyc);
        check32("refetch_latency", cyc, 32'd3);
        check32("refetch_rdata", if_rdata_o, 32'h0000_0088);
        check_grant("refetch", 32'h88, 1'b0, 32'h0);
        tick(1);
        if_req = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
